// File: rtl/printer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : printer_pkg
//  Brief    : Shared types and constants for the pre-print heat sequence:
//             material enum, per-material setpoints, regulator state enum.
//  Revision : 1.0 - initial release
// ============================================================================
package printer_pkg;

    // Filament material latched by the regulator
    typedef enum logic [1:0] {
        MAT_PLA = 2'd0,
        MAT_ABS = 2'd1,
        MAT_TPU = 2'd2
    } material_e;

    // Regulator states; the top level carries these as plain 3-bit codes
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEAT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_READY  = 3'd3,
        ST_FAULT  = 3'd4
    } reg_state_e;

    // Setpoints in degrees C (hotend / bed)
    localparam int unsigned c_PLA_HOTEND_SP = 200;
    localparam int unsigned c_PLA_BED_SP    = 60;
    localparam int unsigned c_ABS_HOTEND_SP = 240;
    localparam int unsigned c_ABS_BED_SP    = 100;
    localparam int unsigned c_TPU_HOTEND_SP = 220;
    localparam int unsigned c_TPU_BED_SP    = 50;

    // Hotend setpoint for a material
    function automatic int unsigned hotend_setpoint(input material_e mat);
        case (mat)
            MAT_ABS: return c_ABS_HOTEND_SP;
            MAT_TPU: return c_TPU_HOTEND_SP;
            default: return c_PLA_HOTEND_SP;
        endcase
    endfunction

    // Bed setpoint for a material
    function automatic int unsigned bed_setpoint(input material_e mat);
        case (mat)
            MAT_ABS: return c_ABS_BED_SP;
            MAT_TPU: return c_TPU_BED_SP;
            default: return c_PLA_BED_SP;
        endcase
    endfunction

    // Request priority ABS > TPU > PLA; PLA is the fall-through choice, so
    // its enable is only needed by the caller to decide whether any is set.
    function automatic material_e select_material(input logic en_abs,
                                                  input logic en_tpu);
        if (en_abs) begin
            return MAT_ABS;
        end else if (en_tpu) begin
            return MAT_TPU;
        end
        return MAT_PLA;
    endfunction

endpackage
`default_nettype wire

// File: rtl/heat_regulator_if.sv
`default_nettype none
// ============================================================================
//  Module   : heat_regulator_if
//  Brief    : Bundle between the bed/hotend sequencing FSM (master) and the
//             heat regulator (slave): heat requests, temperature samples,
//             heater drives and reached/fault flags.
//  Revision : 1.0 - initial release
// ============================================================================
interface heat_regulator_if #(
    parameter int TEMP_W = 10
);
    logic              en_pla;
    logic              en_abs;
    logic              en_tpu;
    logic              sample_valid;
    logic [TEMP_W-1:0] hotend_temp;
    logic [TEMP_W-1:0] bed_temp;
    logic              hotend_on;
    logic              bed_on;
    logic              t_pla;
    logic              t_abs;
    logic              t_tpu;
    logic              fault;

    modport master (
        output en_pla, en_abs, en_tpu, sample_valid, hotend_temp, bed_temp,
        input  hotend_on, bed_on, t_pla, t_abs, t_tpu, fault
    );

    modport slave (
        input  en_pla, en_abs, en_tpu, sample_valid, hotend_temp, bed_temp,
        output hotend_on, bed_on, t_pla, t_abs, t_tpu, fault
    );
endinterface
`default_nettype wire

// File: rtl/heat_channel.sv
`default_nettype none
// ============================================================================
//  Module   : heat_channel
//  Brief    : One heater channel: bang-bang drive register with a hysteresis
//             band below the setpoint, plus in-band and over-temperature
//             compares on the current sample.
//  Revision : 1.0 - initial release
// ============================================================================
module heat_channel
    import printer_pkg::*;
#(
    parameter int TEMP_W      = 10,
    parameter int HYST        = 4,
    parameter int OVER_MARGIN = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_regulate,
    input  logic              i_sample_valid,
    input  logic [TEMP_W-1:0] i_setpoint,
    input  logic [TEMP_W-1:0] i_temp,
    output logic              o_drive,
    output logic              o_in_band,
    output logic              o_over_temp
);

    logic [TEMP_W-1:0] w_low_thr;
    logic [TEMP_W:0]   w_over_thr;
    logic              r_drive;

    // Lower band edge cannot underflow for the supported setpoints; the
    // over-temperature limit gets one extra bit so it never wraps.
    assign w_low_thr   = i_setpoint - TEMP_W'(HYST);
    assign w_over_thr  = {1'b0, i_setpoint} + (TEMP_W + 1)'(OVER_MARGIN);
    assign o_in_band   = (i_temp >= w_low_thr);
    assign o_over_temp = ({1'b0, i_temp} > w_over_thr);

    // Hysteresis drive: on below the band, off at/above setpoint, else hold
    always_ff @(posedge clk) begin
        if (!reset || i_clear) begin
            r_drive <= 1'b0;
        end else if (i_regulate && i_sample_valid) begin
            if (i_temp < w_low_thr) begin
                r_drive <= 1'b1;
            end else if (i_temp >= i_setpoint) begin
                r_drive <= 1'b0;
            end
        end
    end

    assign o_drive = r_drive;

endmodule
`default_nettype wire

// File: rtl/heat_regulator.sv
`default_nettype none
// ============================================================================
//  Module   : heat_regulator
//  Brief    : Closed-loop hotend/bed regulator for the pre-print sequence.
//             Latches the requested material, drives both heaters with
//             hysteresis control and raises the material's reached flag once
//             SETTLE_CYC consecutive samples are in band.
//             Optional build macro HEAT_REGULATOR_SAFETY_EN adds a HEAT
//             timeout and an over-temperature trip into a latched FAULT.
//  Revision : 1.0 - initial release
// ============================================================================
module heat_regulator
    import printer_pkg::*;
#(
    parameter int TEMP_W      = 10,
    parameter int HYST        = 4,
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 4096,
    parameter int OVER_MARGIN = 15
) (
    input  logic             clk,
    input  logic             reset,
    heat_regulator_if.slave  bus
);

    localparam logic [2:0] c_IDLE   = ST_IDLE;
    localparam logic [2:0] c_HEAT   = ST_HEAT;
    localparam logic [2:0] c_SETTLE = ST_SETTLE;
    localparam logic [2:0] c_READY  = ST_READY;
    localparam logic [2:0] c_FAULT  = ST_FAULT;

    localparam int c_CNT_W = $clog2(SETTLE_CYC + 1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    material_e          r_mat;
    material_e          w_mat_nxt;
    material_e          w_sel;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_CNT_W-1:0] w_cnt_inc;

    logic               w_any;
    logic               w_active;
    logic               w_mat_change;
    logic               w_regulate;
    logic               w_trip;
    logic               w_ch_clear;
    logic               w_both_in_band;

    logic [TEMP_W-1:0]  w_hot_sp;
    logic [TEMP_W-1:0]  w_bed_sp;
    logic               w_hot_in_band;
    logic               w_bed_in_band;
    logic               w_hot_over;
    logic               w_bed_over;
    logic               w_hot_drive;
    logic               w_bed_drive;

    logic               r_t_pla;
    logic               r_t_abs;
    logic               r_t_tpu;

    assign w_any          = bus.en_pla | bus.en_abs | bus.en_tpu;
    assign w_sel          = select_material(bus.en_abs, bus.en_tpu);
    assign w_active       = (r_state == c_HEAT) || (r_state == c_SETTLE) ||
                            (r_state == c_READY);
    assign w_mat_change   = w_active && w_any && (w_sel != r_mat);
    assign w_both_in_band = w_hot_in_band && w_bed_in_band;
    assign w_cnt_inc      = r_cnt + c_CNT_W'(1);

    assign w_hot_sp = TEMP_W'(hotend_setpoint(r_mat));
    assign w_bed_sp = TEMP_W'(bed_setpoint(r_mat));

    // Heaters only follow samples while regulating the latched material; the
    // cycle of a material change holds the drives so the new setpoints take
    // effect from the next sample on.
    assign w_regulate = w_active && w_any && !w_mat_change;
    assign w_ch_clear = (w_state_nxt == c_IDLE) || (w_state_nxt == c_FAULT);

    heat_channel #(
        .TEMP_W      (TEMP_W),
        .HYST        (HYST),
        .OVER_MARGIN (OVER_MARGIN)
    ) u_hotend (
        .clk            (clk),
        .reset          (reset),
        .i_clear        (w_ch_clear),
        .i_regulate     (w_regulate),
        .i_sample_valid (bus.sample_valid),
        .i_setpoint     (w_hot_sp),
        .i_temp         (bus.hotend_temp),
        .o_drive        (w_hot_drive),
        .o_in_band      (w_hot_in_band),
        .o_over_temp    (w_hot_over)
    );

    heat_channel #(
        .TEMP_W      (TEMP_W),
        .HYST        (HYST),
        .OVER_MARGIN (OVER_MARGIN)
    ) u_bed (
        .clk            (clk),
        .reset          (reset),
        .i_clear        (w_ch_clear),
        .i_regulate     (w_regulate),
        .i_sample_valid (bus.sample_valid),
        .i_setpoint     (w_bed_sp),
        .i_temp         (bus.bed_temp),
        .o_drive        (w_bed_drive),
        .o_in_band      (w_bed_in_band),
        .o_over_temp    (w_bed_over)
    );

`ifdef HEAT_REGULATOR_SAFETY_EN
    localparam int c_TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [c_TMO_W-1:0] r_tmo;
    logic               r_fault;

    // Trip on an over-hot sample or on the last permitted HEAT cycle; a
    // material change takes precedence since it restarts heating anyway.
    assign w_trip = w_regulate &&
                    ((bus.sample_valid && (w_hot_over || w_bed_over)) ||
                     ((r_state == c_HEAT) &&
                      (r_tmo == c_TMO_W'(TIMEOUT_CYC - 1))));

    // HEAT dwell counter, restarted whenever HEAT is (re)entered
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tmo <= '0;
        end else if ((r_state == c_HEAT) && (w_state_nxt == c_HEAT) &&
                     !w_mat_change) begin
            r_tmo <= r_tmo + c_TMO_W'(1);
        end else begin
            r_tmo <= '0;
        end
    end

    // Registered fault flag mirrors residence in FAULT
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= (w_state_nxt == c_FAULT);
        end
    end

    assign bus.fault = r_fault;
`else
    logic w_unused_safety;

    localparam int c_unused_timeout = TIMEOUT_CYC;

    assign w_trip          = 1'b0;
    assign w_unused_safety = &{1'b0, w_hot_over, w_bed_over};
    assign bus.fault       = 1'b0;
`endif

    // Next-state, material latch and settle count
    always_comb begin
        w_state_nxt = r_state;
        w_mat_nxt   = r_mat;
        w_cnt_nxt   = r_cnt;
        if (r_state == c_FAULT) begin
            if (!w_any) begin
                w_state_nxt = c_IDLE;
            end
        end else if (!w_any) begin
            w_state_nxt = c_IDLE;
            w_cnt_nxt   = '0;
        end else if (r_state == c_IDLE) begin
            w_state_nxt = c_HEAT;
            w_mat_nxt   = w_sel;
            w_cnt_nxt   = '0;
        end else if (w_mat_change) begin
            w_state_nxt = c_HEAT;
            w_mat_nxt   = w_sel;
            w_cnt_nxt   = '0;
        end else if (w_trip) begin
            w_state_nxt = c_FAULT;
            w_cnt_nxt   = '0;
        end else if (bus.sample_valid) begin
            case (r_state)
                c_HEAT: begin
                    if (w_both_in_band) begin
                        w_state_nxt = (SETTLE_CYC <= 1) ? c_READY : c_SETTLE;
                        w_cnt_nxt   = c_CNT_W'(1);
                    end
                end
                c_SETTLE: begin
                    if (w_both_in_band) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_CNT_W'(SETTLE_CYC)) begin
                            w_state_nxt = c_READY;
                        end
                    end else begin
                        w_state_nxt = c_HEAT;
                        w_cnt_nxt   = '0;
                    end
                end
                c_READY: begin
                    if (!w_both_in_band) begin
                        w_state_nxt = c_HEAT;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, material and settle counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_mat   <= MAT_PLA;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mat   <= w_mat_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Reached flags: only the latched material's flag, only while READY
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_t_pla <= 1'b0;
            r_t_abs <= 1'b0;
            r_t_tpu <= 1'b0;
        end else begin
            r_t_pla <= (w_state_nxt == c_READY) && (w_mat_nxt == MAT_PLA);
            r_t_abs <= (w_state_nxt == c_READY) && (w_mat_nxt == MAT_ABS);
            r_t_tpu <= (w_state_nxt == c_READY) && (w_mat_nxt == MAT_TPU);
        end
    end

    assign bus.hotend_on = w_hot_drive;
    assign bus.bed_on    = w_bed_drive;
    assign bus.t_pla     = r_t_pla;
    assign bus.t_abs     = r_t_abs;
    assign bus.t_tpu     = r_t_tpu;

endmodule
`default_nettype wire

// File: tb/tb_heat_regulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_heat_regulator
//  Brief    : Self-checking bench for heat_regulator: directed sequences with
//             literal expectations plus randomized traffic, all outputs
//             compared every cycle against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_heat_regulator;

    localparam int TEMP_W      = 10;
    localparam int HYST        = 4;
    localparam int SETTLE_CYC  = 8;
    localparam int TIMEOUT_CYC = 4096;
    localparam int OVER_MARGIN = 15;

    logic clk = 1'b0;
    logic reset;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    heat_regulator_if #(.TEMP_W(TEMP_W)) bus ();

    heat_regulator #(
        .TEMP_W      (TEMP_W),
        .HYST        (HYST),
        .SETTLE_CYC  (SETTLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .OVER_MARGIN (OVER_MARGIN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- behavioural model ----------------
    // Material ids: 0 PLA, 1 ABS, 2 TPU
    bit m_active, m_fault, m_hot, m_bed;
    int m_mat, m_run, m_heat_cyc;

    function automatic int sp_hot(input int mat);
        return (mat == 1) ? 240 : (mat == 2) ? 220 : 200;
    endfunction

    function automatic int sp_bed(input int mat);
        return (mat == 1) ? 100 : (mat == 2) ? 50 : 60;
    endfunction

    // m_run counts consecutive in-band samples; 0 means still heating,
    // SETTLE_CYC or more means settled.
    always @(posedge clk) begin : p_model
        int  h, b, hs, bs, sel, run_old;
        bit  any, inb, trip;
        h   = int'(bus.hotend_temp);
        b   = int'(bus.bed_temp);
        any = bus.en_pla || bus.en_abs || bus.en_tpu;
        sel = bus.en_abs ? 1 : (bus.en_tpu ? 2 : 0);
        if (reset !== 1'b1) begin
            m_active = 0; m_fault = 0; m_hot = 0; m_bed = 0;
            m_mat = 0; m_run = 0; m_heat_cyc = 0;
        end else if (m_fault) begin
            if (!any) m_fault = 0;
        end else if (!any) begin
            m_active = 0; m_run = 0; m_hot = 0; m_bed = 0; m_heat_cyc = 0;
        end else if (!m_active) begin
            m_active = 1; m_mat = sel; m_run = 0; m_heat_cyc = 0;
        end else if (sel != m_mat) begin
            m_mat = sel; m_run = 0; m_heat_cyc = 0;
        end else begin
            hs   = sp_hot(m_mat);
            bs   = sp_bed(m_mat);
            trip = 0;
`ifdef HEAT_REGULATOR_SAFETY_EN
            if (bus.sample_valid && (h > hs + OVER_MARGIN || b > bs + OVER_MARGIN)) trip = 1;
            if (m_run == 0 && m_heat_cyc >= TIMEOUT_CYC - 1) trip = 1;
`endif
            if (trip) begin
                m_fault = 1; m_active = 0; m_run = 0;
                m_hot = 0; m_bed = 0; m_heat_cyc = 0;
            end else begin
                run_old = m_run;
                if (bus.sample_valid) begin
                    if (h < hs - HYST) m_hot = 1; else if (h >= hs) m_hot = 0;
                    if (b < bs - HYST) m_bed = 1; else if (b >= bs) m_bed = 0;
                    inb = (h >= hs - HYST) && (b >= bs - HYST);
                    if (!inb) m_run = 0;
                    else if (m_run < SETTLE_CYC) m_run = m_run + 1;
                end
                m_heat_cyc = (run_old == 0 && m_run == 0) ? m_heat_cyc + 1 : 0;
            end
        end
    end

    task automatic cmp(input string name, input logic act, input logic exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model hotend_on", bus.hotend_on, m_hot);
            cmp("model bed_on",    bus.bed_on,    m_bed);
            cmp("model t_pla",     bus.t_pla, m_active && m_run >= SETTLE_CYC && m_mat == 0);
            cmp("model t_abs",     bus.t_abs, m_active && m_run >= SETTLE_CYC && m_mat == 1);
            cmp("model t_tpu",     bus.t_tpu, m_active && m_run >= SETTLE_CYC && m_mat == 2);
            cmp("model fault",     bus.fault, m_fault);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit pla, input bit e_abs, input bit tpu,
                         input bit sv, input int h, input int b);
        bus.en_pla       = pla;
        bus.en_abs       = e_abs;
        bus.en_tpu       = tpu;
        bus.sample_valid = sv;
        bus.hotend_temp  = TEMP_W'(h);
        bus.bed_temp     = TEMP_W'(b);
        @(posedge clk);
        #1;
    endtask

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        bit pla, e_abs, tpu;
        int sel, h, b;
        reset = 1'b0;
        bus.en_pla = 0; bus.en_abs = 0; bus.en_tpu = 0;
        bus.sample_valid = 0; bus.hotend_temp = '0; bus.bed_temp = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        cmp("reset hotend_on", bus.hotend_on, 1'b0);
        cmp("reset bed_on",    bus.bed_on,    1'b0);
        cmp("reset t_pla",     bus.t_pla,     1'b0);
        cmp("reset fault",     bus.fault,     1'b0);
        reset = 1'b1;

        // PLA cold start: heaters engage one cycle after the strobe
        drive(1, 0, 0, 0, 150, 30);
        cmp("idle->heat hotend_on", bus.hotend_on, 1'b0);
        drive(1, 0, 0, 1, 150, 30);
        cmp("cold hotend_on", bus.hotend_on, 1'b1);
        cmp("cold bed_on",    bus.bed_on,    1'b1);
        cmp("cold t_pla",     bus.t_pla,     1'b0);

        // Settle interrupted by an out-of-band 5th sample
        repeat (4) drive(1, 0, 0, 1, 198, 57);
        drive(1, 0, 0, 1, 194, 57);
        cmp("restart t_pla", bus.t_pla, 1'b0);
        cmp("restart hotend_on", bus.hotend_on, 1'b1);
        repeat (7) drive(1, 0, 0, 1, 198, 57);
        cmp("7th sample t_pla", bus.t_pla, 1'b0);
        drive(1, 0, 0, 1, 198, 57);
        cmp("8th sample t_pla", bus.t_pla, 1'b1);

        // Hysteresis while READY
        drive(1, 0, 0, 1, 200, 57);
        cmp("at setpoint hotend_on", bus.hotend_on, 1'b0);
        cmp("at setpoint t_pla", bus.t_pla, 1'b1);
        drive(1, 0, 0, 1, 197, 57);
        cmp("in band hold hotend_on", bus.hotend_on, 1'b0);
        drive(1, 0, 0, 1, 195, 57);
        cmp("below band hotend_on", bus.hotend_on, 1'b1);
        cmp("below band t_pla", bus.t_pla, 1'b0);

        // ABS wins over PLA
        drive(1, 1, 0, 0, 236, 96);
        repeat (7) drive(1, 1, 0, 1, 236, 96);
        cmp("abs 7th t_abs", bus.t_abs, 1'b0);
        drive(1, 1, 0, 1, 236, 96);
        cmp("abs settled t_abs", bus.t_abs, 1'b1);
        cmp("abs settled t_pla", bus.t_pla, 1'b0);
        drive(0, 0, 1, 0, 236, 96);
        cmp("switch to tpu t_abs", bus.t_abs, 1'b0);

        // Reset in the middle of SETTLE, then a fresh TPU run
        repeat (3) drive(0, 0, 1, 1, 218, 48);
        reset = 1'b0;
        drive(0, 0, 1, 1, 218, 48);
        cmp("mid reset hotend_on", bus.hotend_on, 1'b0);
        cmp("mid reset bed_on",    bus.bed_on,    1'b0);
        cmp("mid reset t_tpu",     bus.t_tpu,     1'b0);
        reset = 1'b1;
        drive(0, 0, 1, 0, 218, 48);
        repeat (7) drive(0, 0, 1, 1, 218, 48);
        cmp("tpu 7th t_tpu", bus.t_tpu, 1'b0);
        drive(0, 0, 1, 1, 218, 48);
        cmp("tpu settled t_tpu", bus.t_tpu, 1'b1);

        // Enable drop beats a simultaneous sample
        drive(0, 0, 0, 1, 100, 20);
        cmp("drop t_tpu", bus.t_tpu, 1'b0);
        cmp("drop hotend_on", bus.hotend_on, 1'b0);

        // Randomized traffic around the setpoints
        pla = 1; e_abs = 0; tpu = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                pla   = $urandom_range(0, 1);
                e_abs = ($urandom_range(0, 2) == 0);
                tpu   = $urandom_range(0, 1);
            end
            reset = ($urandom_range(0, 299) != 0);
            sel = e_abs ? 1 : (tpu ? 2 : 0);
            h = sp_hot(sel) + int'($urandom_range(0, 9)) - 5;
            b = sp_bed(sel) + int'($urandom_range(0, 9)) - 5;
            if ($urandom_range(0, 63) == 0) h = int'($urandom_range(0, 1023));
            drive(pla, e_abs, tpu, bit'($urandom_range(0, 3) != 0), h, b);
        end
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

`ifdef HEAT_REGULATOR_SAFETY_EN
        // Stuck hotend: FAULT after exactly TIMEOUT_CYC cycles in HEAT
        drive(0, 1, 0, 0, 100, 96);
        repeat (TIMEOUT_CYC - 1) drive(0, 1, 0, 1, 100, 96);
        cmp("pre-timeout fault", bus.fault, 1'b0);
        drive(0, 1, 0, 1, 100, 96);
        cmp("timeout fault", bus.fault, 1'b1);
        cmp("timeout hotend_on", bus.hotend_on, 1'b0);
        drive(0, 0, 0, 0, 100, 96);
        cmp("fault release", bus.fault, 1'b0);
        // Over-temperature sample
        drive(0, 1, 0, 0, 240, 100);
        drive(0, 1, 0, 1, 256, 100);
        cmp("overtemp fault", bus.fault, 1'b1);
        drive(0, 0, 0, 0, 0, 0);
        cmp("overtemp release", bus.fault, 1'b0);
`endif

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
